// File: rtl/divu_seq.sv
// Iterative restoring unsigned divider (MIPS DIVU): quotient to q (LO), remainder to r (HI).
// One quotient bit per cycle; start/busy/done handshake lets the pipeline stall until done.
module divu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             accept;
   logic             last;

   // quo starts as the dividend; its MSB feeds the remainder while quotient bits fill the LSB
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      shifted   = {rem, quo[WIDTH-1]};
      trial     = shifted - {1'b0, dvs};
      rem_nxt   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt   = {quo[WIDTH-2:0], ~trial[WIDTH]};
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         dz    <= 1'b0;
         q     <= '0;
         r     <= '0;
         cnt   <= '0;
         quo   <= '0;
         dvs   <= '0;
         rem   <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == RUN);
         done  <= last;
         if (accept) begin
            quo <= dividend;
            dvs <= divisor;
            rem <= '0;
            cnt <= '0;
            dz  <= (divisor == '0);
         end else if (state == RUN) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
               q <= quo_nxt;
               r <= rem_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: driver pushes expected results, monitor checks them on done.
module tb_divu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] q;
   logic [31:0] r;
   logic        busy;
   logic        done;
   logic        dz;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   divu_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (reset === 1'b0 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("q", 64'(q), 64'(e.q));
            chk("r", 64'(r), 64'(e.r));
            chk("dz", 64'(dz), 64'(e.dz));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
      exp_t e;
      e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.dz  = (b == 0);
      e.cyc = acc + 32;
      return e;
   endfunction

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy) begin
         n_cmp++;
         n_err++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
      end
   endtask

   // Issue one division; returns at the negedge of cycle 1 of the run
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz, input bit push, output int acc);
      exp_t e;
      wait_idle();
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) begin
         e.q = eq; e.r = er; e.dz = edz; e.cyc = acc + 32;
         sb.push_back(e);
      end
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      chk("busy_after_accept", 64'(busy), 64'd1);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int acc;
      int acc2;
      int t;
      logic [31:0] a;
      logic [31:0] b;
      exp_t e;

      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_q", 64'(q), 64'd0);
      chk("rst_r", 64'(r), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);
      reset = 1'b0;

      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, acc);
      issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, acc);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, acc);
      issue(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, acc);
      issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, acc);

      // start during a run is dropped
      issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1, acc);
      repeat (9) @(negedge clk);
      start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignored_start", 64'(busy), 64'd1);
      drain();
      repeat (40) @(negedge clk);

      // reset aborts a run without a done pulse
      issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, acc);
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_q", 64'(q), 64'd0);
      chk("abort_r", 64'(r), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_dz", 64'(dz), 64'd0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1, acc);
      drain();

      // back-to-back with start held high, operands switched at done
      wait_idle();
      start = 1'b1; dividend = 32'd81; divisor = 32'd9;
      @(posedge clk);
      #1;
      acc = cyc;
      e.q = 32'd9; e.r = 32'd0; e.dz = 1'b0; e.cyc = acc + 32;
      sb.push_back(e);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 100);
      dividend = 32'd82;
      @(posedge clk);
      #1;
      acc2 = cyc;
      e.q = 32'd9; e.r = 32'd1; e.dz = 1'b0; e.cyc = acc2 + 32;
      sb.push_back(e);
      chk("b2b_accept_gap", 64'(acc2 - acc), 64'd33);
      @(negedge clk);
      start = 1'b0;
      drain();

      // random operands against the reference model
      for (int i = 0; i < 16; i++) begin
         a = (i % 3 == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
         case (i % 4)
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = 32'h8000_0000;
            default: b = (i % 8 == 3) ? 32'($urandom_range(1, 50)) : 32'($urandom);
         endcase
         e = model(a, b, 0);
         issue(a, b, e.q, e.r, e.dz, 1'b1, acc);
      end
      drain();

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
